// File: rtl/siso_deser_rx.sv
`default_nettype none
// ============================================================================
// Module      : siso_deser_rx
// Description : Serial receiver at the tail of the SISO flip-flop chain.
//               Hunts for a sync word, verifies alignment, then packs the
//               bit stream into WIDTH-bit words delivered through a 2-entry
//               valid/ready buffer with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module siso_deser_rx #(
    parameter int         WIDTH    = 8,
    parameter [WIDTH-1:0] SYNC     = 8'hA5,
    parameter int         LOCK_CNT = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SHIFT_EN,
    input  logic             SIN,
    input  logic             RESYNC,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             LOCKED,
    output logic             OVERFLOW,
    input  logic             CLR_OVF
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       LOCK_N   = 3'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       sync_cnt, sync_cnt_n;
    logic [WIDTH-1:0] window;
    logic             push;

    logic [WIDTH-1:0] head, tail;
    logic [1:0]       count;
    logic             pop;

    // Window as it will look once the current bit is shifted in.
    assign window = {sr[WIDTH-2:0], SIN};

    // Shift register, alignment counters and state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= HUNT;
            sr       <= '0;
            bit_cnt  <= '0;
            sync_cnt <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            sync_cnt <= sync_cnt_n;
            if (SHIFT_EN) sr <= window;
        end
    end

    // Alignment state machine; raises push on the last bit of a locked word.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        sync_cnt_n = sync_cnt;
        push       = 1'b0;
        if (RESYNC) begin
            state_n    = HUNT;
            bit_cnt_n  = '0;
            sync_cnt_n = '0;
        end else if (SHIFT_EN) begin
            case (state)
                HUNT: begin
                    if (window == SYNC) begin
                        bit_cnt_n  = '0;
                        sync_cnt_n = 3'd1;
                        state_n    = (LOCK_CNT == 1) ? LOCK : VERIFY;
                    end
                end
                VERIFY: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (window == SYNC) begin
                            sync_cnt_n = sync_cnt + 3'd1;
                            if (sync_cnt + 3'd1 == LOCK_N) state_n = LOCK;
                        end else begin
                            sync_cnt_n = '0;
                            state_n    = HUNT;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                LOCK: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        push      = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n    = HUNT;
                    bit_cnt_n  = '0;
                    sync_cnt_n = '0;
                end
            endcase
        end
    end

    assign pop = DVALID & DREADY;

    // Two-entry output buffer: head drives DOUT, tail holds the second word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= window;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= window;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= window;
                    end else begin
                        head <= tail;
                        tail <= window;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                     OVERFLOW <= 1'b0;
        else if (push && !pop && (count == 2'd2))      OVERFLOW <= 1'b1;
        else if (CLR_OVF)                              OVERFLOW <= 1'b0;
    end

    assign DOUT   = head;
    assign DVALID = (count != 2'd0);
    assign LOCKED = (state == LOCK);

endmodule
`default_nettype wire
